// File: rtl/mme_mac_array.sv
// Parametrised NxN output-stationary MAC array: one A column and one B row per beat,
// accumulating C = A x B, then streaming the C rows out under valid/ready.
module mme_mac_array #(
   parameter int unsigned N      = 4,
   parameter int unsigned DW     = 32,
   parameter int unsigned ACCW   = 32,
   parameter int unsigned CNTW   = 16,
   parameter bit          SIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNTW-1:0]   mat_width,
   input  logic              a_valid,
   input  logic [N*DW-1:0]   a_data,
   input  logic              b_valid,
   input  logic [N*DW-1:0]   b_data,
   output logic              ab_ready,
   output logic              c_valid,
   output logic [N*ACCW-1:0] c_data,
   input  logic              c_ready,
   output logic              busy,
   output logic              done
);

   localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW = (ACCW > 2 * DW) ? ACCW : 2 * DW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   k_q, k_d;
   logic [CNTW-1:0]   beat_q, beat_d;
   logic [RW-1:0]     row_q, row_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              s1_v_q, s1_v_d;
   logic [N*DW-1:0]   a_r_q, a_r_d;
   logic [N*DW-1:0]   b_r_q, b_r_d;
   logic [ACCW-1:0]   acc_q [N][N];
   logic [ACCW-1:0]   acc_d [N][N];

   logic              fire;
   logic              accept;

   // Full-precision product, sign- or zero-extended to the wider of the two widths,
   // then reduced to ACCW so the accumulator wraps modulo 2^ACCW.
   function automatic logic [ACCW-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [2*DW-1:0] ps;
      logic        [2*DW-1:0] pu;
      if (SIGNED) begin
         ps = $signed(a) * $signed(b);
         return ACCW'(PW'(ps));
      end else begin
         pu = a * b;
         return ACCW'(PW'(pu));
      end
   endfunction

   assign fire   = (state_q == S_LOAD) && a_valid && b_valid;
   assign accept = (state_q == S_IDLE) && start && !busy_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      beat_d  = beat_q;
      row_d   = row_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               k_d     = mat_width;
               beat_d  = '0;
               row_d   = '0;
               busy_d  = 1'b1;
               state_d = (mat_width == '0) ? S_DRAIN : S_LOAD;
            end else if (done_q) begin
               busy_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (fire) begin
               beat_d = beat_q + CNTW'(1);
               if (beat_q == k_q - CNTW'(1)) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (!s1_v_q) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (c_ready) begin
               if (row_q == RW'(N - 1)) begin
                  row_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stage 1 captures the beat; stage 2 performs the rank-1 update of C.
   always_comb begin
      s1_v_d = fire;
      a_r_d  = a_r_q;
      b_r_d  = b_r_q;
      if (fire) begin
         a_r_d = a_data;
         b_r_d = b_data;
      end
   end

   always_comb begin
      acc_d = acc_q;
      if (accept) begin
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               acc_d[i][j] = '0;
            end
         end
      end else if (s1_v_q) begin
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               acc_d[i][j] = acc_q[i][j] + mac_term(a_r_q[i*DW +: DW], b_r_q[j*DW +: DW]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         beat_q  <= '0;
         row_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         s1_v_q  <= 1'b0;
         a_r_q   <= '0;
         b_r_q   <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               acc_q[i][j] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         beat_q  <= beat_d;
         row_q   <= row_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         s1_v_q  <= s1_v_d;
         a_r_q   <= a_r_d;
         b_r_q   <= b_r_d;
         acc_q   <= acc_d;
      end
   end

   assign ab_ready = (state_q == S_LOAD);
   assign c_valid  = (state_q == S_DRAIN);
   assign busy     = busy_q;
   assign done     = done_q;

   always_comb begin
      c_data = '0;
      if (state_q == S_DRAIN) begin
         for (int unsigned j = 0; j < N; j++) begin
            c_data[j*ACCW +: ACCW] = acc_q[row_q][j];
         end
      end
   end

endmodule

// File: tb/tb_mme_mac_array.sv
// Table-driven bench for mme_mac_array (N=4, 32-bit signed) with a row scoreboard,
// plus hand-written reset, abort and start-while-busy sequences.
module tb_mme_mac_array;

   localparam int unsigned N    = 4;
   localparam int unsigned DW   = 32;
   localparam int unsigned ACCW = 32;
   localparam int unsigned CNTW = 16;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [CNTW-1:0]   mat_width;
   logic              a_valid;
   logic [N*DW-1:0]   a_data;
   logic              b_valid;
   logic [N*DW-1:0]   b_data;
   logic              ab_ready;
   logic              c_valid;
   logic [N*ACCW-1:0] c_data;
   logic              c_ready = 1'b0;
   logic              busy;
   logic              done;

   mme_mac_array #(
      .N(N), .DW(DW), .ACCW(ACCW), .CNTW(CNTW), .SIGNED(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mat_width(mat_width),
      .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
      .ab_ready(ab_ready), .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned k;
      logic [31:0] a   [16][4];
      logic [31:0] b   [16][4];
      logic [31:0] exp [4][4];
      bit          rnd;
      bit          poke;
   } vec_t;

   vec_t              tbl [7];
   int                n_vec = 0;
   int                n_bad = 0;
   logic [127:0]      sb [$];
   int                rows_seen, done_seen, abr_seen;
   bit                rdy_slow = 1'b0;
   int unsigned       rcyc = 0;
   logic [31:0]       ja [16][4];
   logic [31:0]       jb [16][4];
   bit                stall_q = 1'b0;
   logic [127:0]      stall_data;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      rcyc++;
      c_ready = rdy_slow ? (rcyc % 3 == 0) : 1'b1;
   end

   // Output monitor: pops the scoreboard on every accepted row, checks stall stability.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ab_ready) abr_seen++;
         if (done) done_seen++;
         if (c_valid) begin
            if (stall_q) check("row_stable", c_data, stall_data);
            if (c_ready) begin
               rows_seen++;
               if (sb.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_row: got %h expected no row", c_data);
               end else begin
                  check("c_row", c_data, sb.pop_front());
               end
            end
         end
         stall_q    = c_valid && !c_ready;
         stall_data = c_data;
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic drive_beats(input int unsigned nb, input bit rnd);
      int unsigned idx = 0;
      int unsigned cyc = 0;
      bit          fired;
      while (idx < nb && cyc < 1000) begin
         a_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         b_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int unsigned i = 0; i < 4; i++) begin
            a_data[i*32 +: 32] = ja[idx][i];
            b_data[i*32 +: 32] = jb[idx][i];
         end
         @(negedge clk);
         fired = ab_ready && a_valid && b_valid;
         @(posedge clk);
         #1;
         cyc++;
         if (fired) idx++;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_data  = {4{$urandom()}};
      b_data  = {4{$urandom()}};
      if (idx < nb) begin
         n_vec++;
         n_bad++;
         $display("FAIL beat_timeout: got %0d beats expected %0d", idx, nb);
      end
   endtask

   task automatic run_job(input vec_t v);
      int          cyc;
      int          lat;
      logic [127:0] row;
      cyc = 0;
      while (busy && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      rdy_slow = v.rnd;
      ja = v.a;
      jb = v.b;
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned j = 0; j < 4; j++) row[j*32 +: 32] = v.exp[r][j];
         sb.push_back(row);
      end
      rows_seen = 0;
      done_seen = 0;
      abr_seen  = 0;
      start     = 1'b1;
      mat_width = 16'(v.k);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", 128'(busy), 128'd1);
      drive_beats(v.k, v.rnd);
      if (v.k != 0) begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!c_valid && lat < 20);
         check("fire_to_cvalid_latency", 128'(lat), 128'd3);
      end
      if (v.poke) begin
         @(posedge clk);
         #1;
         start     = 1'b1;
         mat_width = 16'd4;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done || cyc >= 300) break;
      end
      if (!done) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_timeout: got no done expected done within 300 cycles");
      end else begin
         check("busy_at_done", 128'(busy), 128'd1);
         if (v.poke) begin
            start     = 1'b1;
            mat_width = 16'd2;
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check("rows_per_job", 128'(rows_seen), 128'd4);
      check("done_pulses", 128'(done_seen), 128'd1);
      check("scoreboard_empty", 128'(sb.size()), 128'd0);
      check("busy_after_done", 128'(busy), 128'd0);
      if (v.k == 0) check("no_ab_ready_k0", 128'(abr_seen), 128'd0);
      if (v.poke) begin
         repeat (3) @(posedge clk);
         #1;
         check("start_ignored_idle", 128'({busy, c_valid, ab_ready}), 128'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      mat_width = '0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      a_data    = '0;
      b_data    = '0;

      for (int unsigned t = 0; t < 7; t++) begin
         tbl[t].k    = 0;
         tbl[t].rnd  = 1'b0;
         tbl[t].poke = 1'b0;
         for (int unsigned k = 0; k < 16; k++) begin
            for (int unsigned i = 0; i < 4; i++) begin
               tbl[t].a[k][i] = '0;
               tbl[t].b[k][i] = '0;
            end
         end
         for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned j = 0; j < 4; j++) tbl[t].exp[r][j] = '0;
         end
      end
      // 0: identity A, counting B; 6: same job with start poked during DRAIN and at done
      for (int unsigned k = 0; k < 4; k++) begin
         for (int unsigned i = 0; i < 4; i++) begin
            tbl[0].a[k][i]   = (i == k) ? 32'd1 : 32'd0;
            tbl[0].b[k][i]   = 32'(4 * k + i + 1);
            tbl[0].exp[k][i] = 32'(4 * k + i + 1);
         end
      end
      tbl[0].k    = 4;
      tbl[6]      = tbl[0];
      tbl[6].poke = 1'b1;
      tbl[1].k    = 0;
      tbl[2].k    = 1;
      tbl[3].k    = 1;
      tbl[4].k    = 4;
      for (int unsigned i = 0; i < 4; i++) begin
         tbl[2].a[0][i] = 32'hFFFF_FFFF;
         tbl[2].b[0][i] = 32'd2;
         tbl[3].a[0][i] = 32'h8000_0000;
         tbl[3].b[0][i] = 32'h8000_0000;
         for (int unsigned r = 0; r < 4; r++) tbl[2].exp[r][i] = 32'hFFFF_FFFE;
         for (int unsigned k = 0; k < 4; k++) begin
            tbl[4].a[k][i] = 32'hFFFF_FFFF;
            tbl[4].b[k][i] = 32'(i + 1);
         end
         for (int unsigned r = 0; r < 4; r++) tbl[4].exp[r][i] = 32'(-4 * int'(i + 1));
      end
      tbl[5].k   = 16;
      tbl[5].rnd = 1'b1;
      for (int unsigned k = 0; k < 16; k++) begin
         for (int unsigned i = 0; i < 4; i++) begin
            tbl[5].a[k][i] = $urandom_range(0, 255);
            tbl[5].b[k][i] = $urandom_range(0, 255);
         end
      end
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned j = 0; j < 4; j++) begin
            for (int unsigned k = 0; k < 16; k++) begin
               tbl[5].exp[r][j] = tbl[5].exp[r][j] + tbl[5].a[k][r] * tbl[5].b[k][j];
            end
         end
      end

      // Reset held with random stimulus: every output must sit at zero.
      for (int unsigned c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         start     = 1'($urandom_range(0, 1));
         mat_width = 16'($urandom_range(0, 8));
         a_valid   = 1'($urandom_range(0, 1));
         b_valid   = 1'($urandom_range(0, 1));
         a_data    = {4{$urandom()}};
         b_data    = {4{$urandom()}};
         @(negedge clk);
         check("reset_outputs", 128'({ab_ready, c_valid, busy, done}) | c_data, 128'd0);
      end
      start   = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int unsigned t = 0; t < 7; t++) run_job(tbl[t]);

      // Abort after 3 of 8 beats, then a clean identity job must show no residue.
      rdy_slow = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         for (int unsigned i = 0; i < 4; i++) begin
            ja[k][i] = 32'h1111_0000 + 32'(k * 4 + i);
            jb[k][i] = 32'h0000_7777 + 32'(k);
         end
      end
      start     = 1'b1;
      mat_width = 16'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      drive_beats(3, 1'b0);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", 128'({ab_ready, c_valid, busy, done}) | c_data, 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_idle", 128'({ab_ready, c_valid, busy, done}), 128'd0);
      run_job(tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
